btn_input_ctrl: RTL and testbench

- Multi-channel successor to the single-button debouncer feeding the system PIO (volume -/+ today; OSD navigation keys next).
- Per channel: synchronises the raw input, debounces it, classifies press / long-press / release, and generates auto-repeat while held.
- Per-channel sticky event flags let the RISC-V firmware poll without missing short presses.
- Sits between the board button pins and the pio_0 ctrl_in export, in the clk40 domain.

---
 rtl/btn_pkg.sv | 16 +
 rtl/btn_chan.sv | 164 ++++++++++++++++
 rtl/btn_input_ctrl.sv | 56 +++++
 tb/tb_btn_input_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button input controller.
//   btn_state_e : per-channel press-classification FSM states
//   cnt_width() : counter width able to hold 0..n without wrap
package btn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StHeld
  } btn_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchroniser, polarity stage, debouncer,
// press/long/repeat/release classifier and sticky event flag.
// Ports:
//   i_clk      system clock (clk40)
//   reset_n    asynchronous active-low reset
//   i_btn      raw button pin, asynchronous
//   i_evt_clr  clear of the sticky flag, 1-cycle pulse
//   o_btn      debounced level, 1 = pressed
//   o_press    1-cycle pulse on debounced press
//   o_release  1-cycle pulse on debounced release
//   o_long     1-cycle pulse when the hold reaches LONG_CYCLES
//   o_repeat   1-cycle auto-repeat pulse
//   o_evt      sticky flag set by press/long/repeat
module btn_chan #(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned MIN_PULSE_WIDTH = 25000,
  parameter int unsigned LONG_CYCLES     = 20000000,
  parameter int unsigned REPEAT_CYCLES   = 4000000
) (
  input  logic i_clk,
  input  logic reset_n,
  input  logic i_btn,
  input  logic i_evt_clr,
  output logic o_btn,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat,
  output logic o_evt
);

  import btn_pkg::*;

  localparam int unsigned DebW    = cnt_width(MIN_PULSE_WIDTH);
  localparam int unsigned HoldMax = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HoldW   = cnt_width(HoldMax);

  localparam logic [DebW-1:0]  DebLast    = DebW'(MIN_PULSE_WIDTH - 1);
  localparam logic [HoldW-1:0] LongLast   = HoldW'(LONG_CYCLES - 1);
  localparam logic [HoldW-1:0] RepeatLast = HoldW'(REPEAT_CYCLES - 1);
  // Raw pin level that means "not pressed".
  localparam logic             IdleLevel  = ACTIVE_LOW;

  logic             sync1_q, sync2_q;
  logic             norm_q;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic             deb_q, deb_d;
  logic             deb_differ, deb_flip, rise, fall;
  btn_state_e       state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             evt_q, evt_d;

  // Debouncer: count consecutive cycles the normalised input differs from
  // the debounced state; flip once the run reaches MIN_PULSE_WIDTH.
  always_comb begin
    deb_differ = norm_q ^ deb_q;
    deb_flip   = deb_differ && (deb_cnt_q == DebLast);
    deb_d      = deb_q ^ deb_flip;
    if (!deb_differ || deb_flip) begin
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DebW'(1);
    end
    rise = deb_flip & ~deb_q;
    fall = deb_flip & deb_q;
  end

  // Classifier. Pulses are registered alongside deb_q so o_press/o_release
  // line up with the o_btn edge. A fall takes priority over long/repeat.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          press_d = 1'b1;
          hold_d  = '0;
          state_d = StPressed;
        end
      end
      StPressed: begin
        if (fall) begin
          release_d = 1'b1;
          hold_d    = '0;
          state_d   = StIdle;
        end else if (hold_q == LongLast) begin
          long_d  = 1'b1;
          hold_d  = '0;
          state_d = StHeld;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StHeld: begin
        if (fall) begin
          release_d = 1'b1;
          hold_d    = '0;
          state_d   = StIdle;
        end else if (hold_q == RepeatLast) begin
          repeat_d = 1'b1;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = '0;
      end
    endcase
  end

  // Set from the visible pulses so a clear in the same cycle as a pulse loses.
  always_comb begin
    evt_d = press_q | long_q | repeat_q | (evt_q & ~i_evt_clr);
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= IdleLevel;
      sync2_q   <= IdleLevel;
      norm_q    <= 1'b0;
      deb_cnt_q <= '0;
      deb_q     <= 1'b0;
      state_q   <= StIdle;
      hold_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      evt_q     <= 1'b0;
    end else begin
      sync1_q   <= i_btn;
      sync2_q   <= sync1_q;
      // Registered polarity stage: step-to-o_btn latency is MIN_PULSE_WIDTH+2.
      norm_q    <= sync2_q ^ ACTIVE_LOW;
      deb_cnt_q <= deb_cnt_d;
      deb_q     <= deb_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      evt_q     <= evt_d;
    end
  end

  assign o_btn     = deb_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_evt     = evt_q;

endmodule

// File: rtl/btn_input_ctrl.sv
// Multi-channel button input controller for the pio_0 ctrl_in export
// (PIO input word is {o_btn, o_evt, 28'h0} with N_CH = 2).
// Ports (all vectors are N_CH wide, one bit per channel):
//   i_clk      system clock (clk40)
//   reset_n    asynchronous active-low reset
//   i_btn      raw button pins, asynchronous
//   i_evt_clr  per-channel sticky-flag clear, 1-cycle pulse
//   o_btn      debounced level, 1 = pressed
//   o_press    press pulse
//   o_release  release pulse
//   o_long     long-press pulse
//   o_repeat   auto-repeat pulse
//   o_evt      sticky event flag
module btn_input_ctrl #(
  parameter int unsigned N_CH            = 2,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned MIN_PULSE_WIDTH = 25000,
  parameter int unsigned LONG_CYCLES     = 20000000,
  parameter int unsigned REPEAT_CYCLES   = 4000000
) (
  input  logic            i_clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] i_btn,
  input  logic [N_CH-1:0] i_evt_clr,
  output logic [N_CH-1:0] o_btn,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_repeat,
  output logic [N_CH-1:0] o_evt
);

  import btn_pkg::*;

  // Channels are fully independent.
  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    btn_chan #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .MIN_PULSE_WIDTH (MIN_PULSE_WIDTH),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .i_clk     (i_clk),
      .reset_n   (reset_n),
      .i_btn     (i_btn[g]),
      .i_evt_clr (i_evt_clr[g]),
      .o_btn     (o_btn[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_long    (o_long[g]),
      .o_repeat  (o_repeat[g]),
      .o_evt     (o_evt[g])
    );
  end

endmodule

// File: tb/tb_btn_input_ctrl.sv
module tb_btn_input_ctrl;

  localparam int N_CH = 2;
  localparam int MPW  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;
  localparam int HIST = MPW + 2;

  logic            i_clk = 1'b0;
  logic            reset_n;
  logic [N_CH-1:0] i_btn, i_evt_clr;
  logic [N_CH-1:0] o_btn, o_press, o_release, o_long, o_repeat, o_evt;

  btn_input_ctrl #(
    .N_CH            (N_CH),
    .ACTIVE_LOW      (1'b1),
    .MIN_PULSE_WIDTH (MPW),
    .LONG_CYCLES     (LONG),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .i_clk     (i_clk),
    .reset_n   (reset_n),
    .i_btn     (i_btn),
    .i_evt_clr (i_evt_clr),
    .o_btn     (o_btn),
    .o_press   (o_press),
    .o_release (o_release),
    .o_long    (o_long),
    .o_repeat  (o_repeat),
    .o_evt     (o_evt)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Pulse bookkeeping: kind 0 press, 1 release, 2 long, 3 repeat.
  int pc[4][N_CH];
  int ev_t[4][N_CH];

  // Reference model: a pin sample window decides the debounced level, and
  // long/repeat come from the age of the current press.
  bit              hist[N_CH][HIST];
  bit              m_deb[N_CH];
  int              press_t[N_CH];
  int              m_t;
  logic [N_CH-1:0] m_press, m_rel, m_long, m_rep, m_evt;

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < HIST; k++) hist[c][k] = 1'b0;
      m_deb[c]   = 1'b0;
      press_t[c] = 0;
    end
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    m_rep   = '0;
    m_evt   = '0;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] np, nr, nl, nrp, ne;
    m_t++;
    for (int c = 0; c < N_CH; c++) begin
      bit all_diff;
      all_diff = 1'b1;
      // Oldest MPW samples: the two newest are still in the synchroniser.
      for (int k = 0; k < MPW; k++) if (hist[c][k] == m_deb[c]) all_diff = 1'b0;
      np[c]  = all_diff & ~m_deb[c];
      nr[c]  = all_diff & m_deb[c];
      nl[c]  = 1'b0;
      nrp[c] = 1'b0;
      if (m_deb[c] && !all_diff) begin
        int age;
        age    = m_t - press_t[c];
        nl[c]  = (age == LONG);
        nrp[c] = (age > LONG) && (((age - LONG) % REP) == 0);
      end
      ne[c] = m_press[c] | m_long[c] | m_rep[c] | (m_evt[c] & ~i_evt_clr[c]);
      if (np[c]) press_t[c] = m_t;
      m_deb[c] = m_deb[c] ^ all_diff;
      for (int k = 0; k < HIST - 1; k++) hist[c][k] = hist[c][k+1];
      hist[c][HIST-1] = ~i_btn[c];
    end
    m_press = np;
    m_rel   = nr;
    m_long  = nl;
    m_rep   = nrp;
    m_evt   = ne;
  endtask

  initial begin
    m_t = 0;
    model_reset();
    forever begin
      @(posedge i_clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  function automatic logic [6*N_CH-1:0] outs();
    return {o_btn, o_press, o_release, o_long, o_repeat, o_evt};
  endfunction

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge i_clk);
      if (chk_en) begin
        logic [N_CH-1:0]   mb;
        logic [6*N_CH-1:0] exp_v;
        for (int c = 0; c < N_CH; c++) mb[c] = m_deb[c];
        exp_v = {mb, m_press, m_rel, m_long, m_rep, m_evt};
        n_chk++;
        if (outs() !== exp_v) begin
          n_err++;
          $display("FAIL model_cycle%0d: got %h expected %h", cyc, outs(), exp_v);
        end
      end
    end
  end

  function automatic logic pick(input int kind, input int ch);
    case (kind)
      0:       return o_press[ch];
      1:       return o_release[ch];
      2:       return o_long[ch];
      default: return o_repeat[ch];
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) for (int c = 0; c < N_CH; c++) begin
      pc[k][c]   = 0;
      ev_t[k][c] = -1;
    end
    forever begin
      @(negedge i_clk);
      for (int k = 0; k < 4; k++) for (int c = 0; c < N_CH; c++) begin
        if (pick(k, c) === 1'b1) begin
          pc[k][c]++;
          if (ev_t[k][c] < 0) ev_t[k][c] = cyc;
        end
      end
    end
  end

  task automatic arm();
    for (int k = 0; k < 4; k++) for (int c = 0; c < N_CH; c++) ev_t[k][c] = -1;
  endtask

  function automatic int total();
    int s = 0;
    for (int k = 0; k < 4; k++) for (int c = 0; c < N_CH; c++) s += pc[k][c];
    return s;
  endfunction

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Returns the cycle of the first pulse of the given kind, -1 on timeout.
  task automatic wait_pulse(input int kind, input int ch, input int max_cyc, output int at);
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (pick(kind, ch) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    int low;
    int np;
    int nr;
    int nl;
    int nrp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int s, at, p0, rs, base;
    int base_pc[4];
    int run[N_CH];

    tbl[0] = '{low: 1,  np: 0, nr: 0, nl: 0, nrp: 0};
    tbl[1] = '{low: 3,  np: 0, nr: 0, nl: 0, nrp: 0};
    tbl[2] = '{low: 4,  np: 1, nr: 1, nl: 0, nrp: 0};
    tbl[3] = '{low: 5,  np: 1, nr: 1, nl: 0, nrp: 0};
    tbl[4] = '{low: 20, np: 1, nr: 1, nl: 0, nrp: 0};  // release on the long cycle
    tbl[5] = '{low: 21, np: 1, nr: 1, nl: 1, nrp: 0};
    tbl[6] = '{low: 28, np: 1, nr: 1, nl: 1, nrp: 0};  // release on the repeat cycle
    tbl[7] = '{low: 29, np: 1, nr: 1, nl: 1, nrp: 1};
    tbl[8] = '{low: 45, np: 1, nr: 1, nl: 1, nrp: 3};

    // 1. Reset
    reset_n   = 1'b0;
    i_btn     = '1;
    i_evt_clr = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_outputs", int'(outs()), 0);
    chk_en = 1'b1;
    tick();
    reset_n = 1'b1;
    base = total();
    repeat (100) tick();
    check("idle_no_pulses", total() - base, 0);
    check("idle_btn_low", int'(o_btn), 0);

    // 2. Glitch, then debounce timing
    base = total();
    i_btn[0] = 1'b0;
    repeat (3) tick();
    i_btn[0] = 1'b1;
    repeat (15) tick();
    check("glitch_no_pulse", total() - base, 0);
    check("glitch_no_btn", int'(o_btn), 0);

    i_btn[0] = 1'b0;
    s = cyc + 1;
    wait_pulse(0, 0, 20, at);
    check("press_latency", at - s, 6);
    check("btn_with_press", int'(o_btn[0]), 1);
    p0 = at;
    tick();
    check("press_width", int'(o_press[0]), 0);
    check("evt_after_press", int'(o_evt[0]), 1);

    // 3/4. Long press, repeats, sticky flag
    wait_pulse(2, 0, 30, at);
    check("long_offset", at - p0, 20);
    wait_pulse(3, 0, 20, at);
    check("repeat1_offset", at - p0, 28);
    tick();
    i_evt_clr[0] = 1'b1;
    tick();
    i_evt_clr[0] = 1'b0;
    check("evt_clear_alone", int'(o_evt[0]), 0);
    wait_pulse(3, 0, 20, at);
    check("repeat2_offset", at - p0, 36);
    wait_pulse(3, 0, 20, at);
    check("repeat3_offset", at - p0, 44);
    i_evt_clr[0] = 1'b1;  // overlaps the visible o_repeat
    tick();
    i_evt_clr[0] = 1'b0;
    check("evt_set_wins", int'(o_evt[0]), 1);
    wait_pulse(3, 0, 20, at);
    check("repeat4_offset", at - p0, 52);
    tick();
    i_btn[0] = 1'b1;
    rs = cyc + 1;
    base = pc[3][0];
    wait_pulse(1, 0, 20, at);
    check("release_latency", at - rs, 6);
    repeat (20) tick();
    check("no_repeat_after_release", pc[3][0] - base, 0);

    // 5. Channel independence
    arm();
    i_btn[0] = 1'b0;
    s = cyc + 1;
    repeat (10) tick();
    i_btn[1] = 1'b0;
    repeat (40) tick();
    check("ch0_press_latency", ev_t[0][0] - s, 6);
    check("ch1_press_offset", ev_t[0][1] - ev_t[0][0], 10);
    check("ch0_long_offset", ev_t[2][0] - ev_t[0][0], 20);
    check("ch1_long_offset", ev_t[2][1] - ev_t[2][0], 10);
    check("ch0_repeat_offset", ev_t[3][0] - ev_t[0][0], 28);
    check("ch1_repeat_offset", ev_t[3][1] - ev_t[3][0], 10);
    arm();
    i_btn = '1;
    rs = cyc + 1;
    repeat (15) tick();
    check("ch0_release_latency", ev_t[1][0] - rs, 6);
    check("ch1_release_latency", ev_t[1][1] - rs, 6);
    repeat (10) tick();

    // 6. Reset while held
    arm();
    i_btn[0] = 1'b0;
    repeat (35) tick();
    check("pre_reset_long", ev_t[2][0] - ev_t[0][0], 20);
    @(posedge i_clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_mid_hold", int'(outs()), 0);
    tick();
    arm();
    reset_n = 1'b1;
    s = cyc + 1;
    repeat (35) tick();
    check("post_reset_press", ev_t[0][0] - s, 6);
    check("post_reset_long", ev_t[2][0] - ev_t[0][0], 20);
    i_btn[0] = 1'b1;
    repeat (20) tick();

    // Table of hold lengths on ch0
    foreach (tbl[i]) begin
      for (int k = 0; k < 4; k++) base_pc[k] = pc[k][0];
      i_btn[0] = 1'b0;
      repeat (tbl[i].low) tick();
      i_btn[0] = 1'b1;
      repeat (45) tick();
      check($sformatf("tbl%0d_press", i), pc[0][0] - base_pc[0], tbl[i].np);
      check($sformatf("tbl%0d_release", i), pc[1][0] - base_pc[1], tbl[i].nr);
      check($sformatf("tbl%0d_long", i), pc[2][0] - base_pc[2], tbl[i].nl);
      check($sformatf("tbl%0d_repeat", i), pc[3][0] - base_pc[3], tbl[i].nrp);
    end

    // Random pins and clears, checked by the model every cycle
    for (int c = 0; c < N_CH; c++) run[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (run[c] == 0) begin
          i_btn[c] = 1'($urandom_range(0, 1));
          run[c]   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(30, 90))
                                                 : int'($urandom_range(1, 12));
        end else begin
          run[c]--;
        end
        i_evt_clr[c] = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    i_evt_clr = '0;
    i_btn     = '1;
    repeat (60) tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
